mem_stage: RTL

- MEM stage of the 5-stage RV32I pipeline, between the ex_mem register and the mem_wb register.
- Executes loads and stores over the shared 8-bit RAM bus. The bus is obtained from the memory arbiter through a req/gnt handshake, and transfers run byte-serial, little-endian.
- Non-memory instructions pass straight through with zero latency.
- While a memory access is in flight, the stage holds the pipeline via mem_stall_req.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_stage_load_ext.sv | 30 +++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Module  : mem_stage_pkg
//  Brief   : Shared types and constants for the RV32I MEM stage.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int RegLen     = 32;
    localparam int RegAddrLen = 5;
    localparam logic [RegLen-1:0] ZERO_WORD = '0;

    // Undefined encodings fold onto NONE so they behave as pass-through.
    function automatic mem_op_e decode_op(input logic [3:0] raw);
        if (raw > 4'd8) begin
            return MEM_NONE;
        end
        return mem_op_e'(raw);
    endfunction

    function automatic logic [2:0] xfer_len(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_ext.sv
// ============================================================================
//  Module  : mem_stage_load_ext
//  Brief   : Assembles captured load bytes and applies sign/zero extension.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  mem_op_e            i_op,
    input  logic [RegLen-1:0]  i_raw,
    output logic [RegLen-1:0]  o_data
);

    always_comb begin
        o_data = ZERO_WORD;
        case (i_op)
            MEM_LB:  o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            MEM_LBU: o_data = {24'h0, i_raw[7:0]};
            MEM_LH:  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            MEM_LHU: o_data = {16'h0, i_raw[15:0]};
            MEM_LW:  o_data = i_raw;
            default: o_data = ZERO_WORD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module  : mem_stage
//  Brief   : RV32I MEM stage; byte-serial loads/stores over the shared RAM bus.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  ex_valid,
    input  logic [3:0]            ex_mem_op,
    input  logic [RegLen-1:0]     ex_rd_data,
    input  logic [RegAddrLen-1:0] ex_rd_addr,
    input  logic                  ex_rd_enable,
    input  logic [31:0]           ex_mem_addr,
    input  logic [31:0]           ex_store_data,
    output logic [RegLen-1:0]     mem_rd_data,
    output logic [RegAddrLen-1:0] mem_rd_addr,
    output logic                  mem_rd_enable,
    output logic                  mem_stall_req,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_wr,
    input  logic [7:0]            bus_rdata
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_nxt;
    mem_op_e             r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_sdata;
    logic [RegLen-1:0]   r_rbytes;

    mem_op_e             w_ex_op;
    logic                w_start;
    logic [2:0]          w_len;
    logic                w_store;
    logic [2:0]          w_cnt_addr;
    logic [ADDR_W-1:0]   w_xfer_addr;
    logic [1:0]          w_cap_idx;
    logic                w_capture;
    logic [RegLen-1:0]   w_load_result;

    assign w_ex_op   = decode_op(ex_mem_op);
    assign w_start   = ex_valid && (w_ex_op != MEM_NONE);
    assign w_len     = xfer_len(r_op);
    assign w_store   = is_store(r_op);
    // The capture-only cycle of a load re-drives the last byte address.
    assign w_cnt_addr  = (r_cnt == w_len) ? (r_cnt - 3'd1) : r_cnt;
    assign w_xfer_addr = r_addr + ADDR_W'(w_cnt_addr);
    assign w_cap_idx   = 2'(r_cnt - 3'd1);
    assign w_capture   = (r_state == ST_XFER) && !w_store && (r_cnt != 3'd0);

    mem_stage_load_ext u_load_ext (
        .i_op   (r_op),
        .i_raw  (r_rbytes),
        .o_data (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_op     <= MEM_NONE;
            r_addr   <= '0;
            r_sdata  <= '0;
            r_rbytes <= ZERO_WORD;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == ST_IDLE) && w_start) begin
                r_op     <= w_ex_op;
                r_addr   <= ADDR_W'(ex_mem_addr);
                r_sdata  <= ex_store_data;
                r_rbytes <= ZERO_WORD;
            end
            // Read data lags its address by one cycle, so byte cnt-1 lands now.
            if (w_capture) begin
                r_rbytes[{w_cap_idx, 3'b000} +: 8] <= bus_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        mem_rd_data   = ex_rd_data;
        mem_rd_addr   = ex_rd_addr;
        mem_rd_enable = 1'b0;
        mem_stall_req = 1'b0;
        bus_req       = 1'b0;
        bus_addr      = '0;
        bus_wdata     = 8'h00;
        bus_wr        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                mem_rd_enable = ex_valid && ex_rd_enable;
                if (w_start) begin
                    mem_rd_enable = 1'b0;
                    mem_stall_req = 1'b1;
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req       = 1'b1;
                mem_stall_req = 1'b1;
                if (bus_gnt) begin
                    w_state_nxt = ST_XFER;
                    w_cnt_nxt   = 3'd0;
                end
            end
            ST_XFER: begin
                bus_req       = 1'b1;
                mem_stall_req = 1'b1;
                bus_addr      = w_xfer_addr;
                if (w_store) begin
                    bus_wr    = 1'b1;
                    bus_wdata = r_sdata[{r_cnt[1:0], 3'b000} +: 8];
                    if (r_cnt == (w_len - 3'd1)) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else begin
                    if (r_cnt == w_len) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (!w_store) begin
                    mem_rd_data   = w_load_result;
                    mem_rd_enable = ex_rd_enable;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (rst) begin
            mem_rd_data   = ZERO_WORD;
            mem_rd_addr   = '0;
            mem_rd_enable = 1'b0;
            mem_stall_req = 1'b0;
            bus_req       = 1'b0;
            bus_addr      = '0;
            bus_wdata     = 8'h00;
            bus_wr        = 1'b0;
        end
    end

endmodule

`default_nettype wire
